intr_ctrl_8085: RTL and testbench
=================================

Name: intr_ctrl_8085

Overview:
Priority interrupt controller that drives the CPU-side interrupt handshake (int_req out, int_ack in) and supplies the 8-bit RST opcode vector during acknowledge. It latches edge-triggered requests from up to 8 peripheral sources and applies a mask register. It tracks in-service levels so that only a higher-priority source can nest, and it retires them on end-of-interrupt (EOI). It sits between the peripheral/IO blocks and the CPU core's interrupt input.

Parameters:
NUM_IRQ, 8, number of request lines (1..8); index 0 = highest priority.
ACK_TIMEOUT, 15, cycles int_req may stay high without int_ack before the request is abandoned.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
irq_in  input  NUM_IRQ  peripheral request lines; rising-edge sensitive.
cfg_we  input  1  when high, write cfg_wdata into mask register IMR.
cfg_wdata  input  NUM_IRQ  new IMR value; 1 = masked.
eoi  input  1  one-cycle pulse: clear highest-priority ISR bit.
int_ack  input  1  CPU acknowledge; level, held until CPU releases.
int_req  output  1  interrupt request to CPU.
vector  output  8  RST opcode for the acknowledged source.
vector_valid  output  1  one-cycle strobe qualifying vector.
spurious  output  1  one-cycle pulse on an acknowledge with no eligible source.
ack_timeout  output  1  one-cycle pulse when ACK_TIMEOUT expires.
irr  output  NUM_IRQ  request register (status).
isr  output  NUM_IRQ  in-service register (status).

Behaviour:
- Reset (rst_n low at clk edge): IRR=0, ISR=0, IMR=all ones, irq_in history=0, int_req=0, vector=8'h00, vector_valid=0, spurious=0, ack_timeout=0, timeout counter=0, FSM=IDLE. Reset overrides every event in the same cycle, including mid-handshake.
- Edge detect: prev register holds irq_in. IRR[i] sets on the edge where irq_in[i]=1 and prev[i]=0. A level held high does not re-set IRR.
- IRR[i] is set regardless of the mask. Eligible[i] = IRR[i] & ~IMR[i] & (no ISR bit at priority <= i).
- Winner = lowest-index eligible bit, recomputed every cycle.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: if any bit is eligible, go to REQ. int_req rises on the next edge. An IRQ edge at edge N therefore gives int_req=1 after edge N+2.
  - REQ: int_req=1 and the timeout counter increments each cycle.
    - int_ack=1 with a winner k: clear IRR[k], set ISR[k], vector=8'hC7|(k<<3), vector_valid=1 for one cycle, int_req=0, go to HOLD.
    - int_ack=1 with no eligible bit (e.g. masked meanwhile): vector=8'hFF, spurious=1, vector_valid=1, ISR unchanged, go to HOLD.
    - No eligible bit and int_ack=0: int_req=0, go to IDLE.
    - Counter reaches ACK_TIMEOUT: ack_timeout=1, int_req=0, go to IDLE. IRR is retained.
  - HOLD: wait for int_ack=0, then go to IDLE. No new int_req is raised while in HOLD.
  - int_ack=1 while in IDLE: treated as spurious (vector 8'hFF, pulse), go to HOLD.
- vector holds its last value after the strobe; only the strobe qualifies it.
- EOI clears the lowest-index set ISR bit. EOI with ISR=0 has no effect.
- EOI in the same cycle as ack setting ISR[k]: the clear applies to the pre-ack ISR and the set of ISR[k] also takes effect.
- IRR[k] cleared by ack in the same cycle as a new edge on irq_in[k]: IRR[k] ends at 1 (the set wins).
- cfg_we takes effect on the next edge. Eligibility uses the registered IMR.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks -> int_req=0, IMR=8'hFF, irr=isr=0, vector=0.
- Single source: IMR=8'hFE, pulse irq_in[0] -> int_req=1 two edges later. Assert int_ack -> vector=8'hC7 with vector_valid pulse, isr=8'h01, irr=0. Then eoi -> isr=0.
- Priority and nesting: IMR=0, raise irq 5 and irq 2 together -> first ack vector=8'hD7, isr=8'h04. Second request is not raised until eoi; second ack vector=8'hEF.
- Nesting: while isr=8'h10, pulse irq 1 -> int_req rises, vector=8'hCF, isr=8'h12. Pulse irq 6 -> no int_req.
- Spurious/mask race: request irq 3, then write IMR=8'hFF before ack -> int_req drops. Ack in IDLE -> vector=8'hFF, spurious pulse, isr unchanged.
- Timeout and reset mid-operation: no int_ack for 15 cycles -> ack_timeout pulse, int_req=0, irr retained. Assert rst_n=0 during REQ -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/intr_ctrl_8085.sv
// Priority interrupt controller for an 8085-style CPU: latches request edges, masks them, tracks in-service levels, answers acknowledges with RST opcodes.
// Latency: an irq_in edge gives int_req two clocks later. int_req waits for int_ack and is abandoned after ACK_TIMEOUT cycles with no acknowledge.
module intr_ctrl_8085 #(
  parameter int NUM_IRQ     = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [NUM_IRQ-1:0] cfg_wdata,
  input  logic               eoi,
  input  logic               int_ack,
  output logic               int_req,
  output logic [7:0]         vector,
  output logic               vector_valid,
  output logic               spurious,
  output logic               ack_timeout,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr
);

  localparam int CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               int_req_q, int_req_d;
  logic [7:0]         vector_q, vector_d;
  logic               vv_q, vv_d;
  logic               spur_q, spur_d;
  logic               tmo_q, tmo_d;

  logic [NUM_IRQ-1:0] elig;
  logic               any_elig;
  logic [2:0]         win_idx;
  logic               blk;
  logic [NUM_IRQ-1:0] irr_clr, isr_set, isr_lo;

  // A source is blocked by any in-service level of equal or higher priority.
  always_comb begin
    blk      = 1'b0;
    elig     = '0;
    win_idx  = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      blk     = blk | isr_q[i];
      elig[i] = irr_q[i] & ~imr_q[i] & ~blk;
    end
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win_idx = 3'(i);
    end
    any_elig = |elig;
  end

  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    vector_d  = vector_q;
    vv_d      = 1'b0;
    spur_d    = 1'b0;
    tmo_d     = 1'b0;
    cnt_d     = '0;
    irr_clr   = '0;
    isr_set   = '0;
    unique case (state_q)
      IDLE: begin
        int_req_d = 1'b0;
        if (int_ack) begin
          vector_d = 8'hFF;
          vv_d     = 1'b1;
          spur_d   = 1'b1;
          state_d  = HOLD;
        end else if (any_elig) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          int_req_d = 1'b0;
          vv_d      = 1'b1;
          state_d   = HOLD;
          if (any_elig) begin
            vector_d = 8'hC7 | {2'b00, win_idx, 3'b000};
            irr_clr  = NUM_IRQ'(1) << win_idx;
            isr_set  = NUM_IRQ'(1) << win_idx;
          end else begin
            vector_d = 8'hFF;
            spur_d   = 1'b1;
          end
        end else if (!any_elig) begin
          int_req_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q == CW'(ACK_TIMEOUT)) begin
          tmo_d     = 1'b1;
          int_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          int_req_d = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        int_req_d = 1'b0;
        if (!int_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge wins over the acknowledge clear; EOI acts on the pre-ack ISR.
    isr_lo = isr_q & (~isr_q + NUM_IRQ'(1));
    prev_d = irq_in;
    irr_d  = (irr_q & ~irr_clr) | (irq_in & ~prev_q);
    isr_d  = (eoi ? (isr_q & ~isr_lo) : isr_q) | isr_set;
    imr_d  = cfg_we ? cfg_wdata : imr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      irr_q     <= '0;
      isr_q     <= '0;
      imr_q     <= '1;
      cnt_q     <= '0;
      int_req_q <= 1'b0;
      vector_q  <= 8'h00;
      vv_q      <= 1'b0;
      spur_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      cnt_q     <= cnt_d;
      int_req_q <= int_req_d;
      vector_q  <= vector_d;
      vv_q      <= vv_d;
      spur_q    <= spur_d;
      tmo_q     <= tmo_d;
    end
  end

  assign int_req      = int_req_q;
  assign vector       = vector_q;
  assign vector_valid = vv_q;
  assign spurious     = spur_q;
  assign ack_timeout  = tmo_q;
  assign irr          = irr_q;
  assign isr          = isr_q;

endmodule

// File: tb/tb_intr_ctrl_8085.sv
// Bench for intr_ctrl_8085: directed stimulus queues expected strobes; a negedge monitor pops and compares them.
module tb_intr_ctrl_8085;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       cfg_we;
  logic [7:0] cfg_wdata;
  logic       eoi;
  logic       int_ack;
  logic       int_req;
  logic [7:0] vector;
  logic       vector_valid;
  logic       spurious;
  logic       ack_timeout;
  logic [7:0] irr;
  logic [7:0] isr;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       tmo;
    logic       spur;
    logic [7:0] vec;
  } exp_t;

  exp_t exp_q[$];

  intr_ctrl_8085 #(.NUM_IRQ(8), .ACK_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_in       (irq_in),
    .cfg_we       (cfg_we),
    .cfg_wdata    (cfg_wdata),
    .eoi          (eoi),
    .int_ack      (int_ack),
    .int_req      (int_req),
    .vector       (vector),
    .vector_valid (vector_valid),
    .spurious     (spurious),
    .ack_timeout  (ack_timeout),
    .irr          (irr),
    .isr          (isr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expect_vec(input logic [7:0] v, input logic sp);
    exp_t e;
    e.tmo  = 1'b0;
    e.spur = sp;
    e.vec  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_tmo();
    exp_t e;
    e.tmo  = 1'b1;
    e.spur = 1'b0;
    e.vec  = 8'h00;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vector_valid === 1'b1 || ack_timeout === 1'b1 || spurious === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: vv=%b spur=%b tmo=%b vec=%h, none expected",
                 vector_valid, spurious, ack_timeout, vector);
      end else begin
        e = exp_q.pop_front();
        if (e.tmo) begin
          if ({ack_timeout, vector_valid, spurious} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_strobe: tmo/vv/spur=%b%b%b expected 100",
                     ack_timeout, vector_valid, spurious);
          end
        end else if ({ack_timeout, vector_valid, spurious, vector} !== {1'b0, 1'b1, e.spur, e.vec}) begin
          bad++;
          $display("FAIL ack_strobe: tmo/vv/spur=%b%b%b vec=%h expected 01%b vec=%h",
                   ack_timeout, vector_valid, spurious, vector, e.spur, e.vec);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_wdata = '0; eoi = 1'b0; int_ack = 1'b0;
    step(2);
    chk("rst_int_req", {7'b0, int_req}, 8'h00);
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_vector", vector, 8'h00);
    chk("rst_strobes", {5'b0, vector_valid, spurious, ack_timeout}, 8'h00);

    // Masked after reset: request latched but not raised
    rst_n = 1'b1;
    irq_in = 8'h01; step(1);
    chk("masked_irr", irr, 8'h01);
    step(2);
    chk("masked_no_req", {7'b0, int_req}, 8'h00);
    irq_in = 8'h00;
    cfg_we = 1'b1; cfg_wdata = 8'hFE; step(1);
    cfg_we = 1'b0; step(1);
    chk("unmask_req_lo", {7'b0, int_req}, 8'h00);
    step(1);
    chk("unmask_req_hi", {7'b0, int_req}, 8'h01);
    expect_vec(8'hC7, 1'b0);
    int_ack = 1'b1; step(1);
    chk("ack0_isr", isr, 8'h01);
    chk("ack0_irr", irr, 8'h00);
    chk("ack0_int_req", {7'b0, int_req}, 8'h00);
    int_ack = 1'b0; step(1);
    eoi = 1'b1; step(1); eoi = 1'b0;
    chk("eoi0_isr", isr, 8'h00);

    // Edge at N gives int_req after N+2
    irq_in = 8'h01; step(1);
    irq_in = 8'h00; step(1);
    chk("lat_n1", {7'b0, int_req}, 8'h00);
    step(1);
    chk("lat_n2", {7'b0, int_req}, 8'h01);
    expect_vec(8'hC7, 1'b0);
    int_ack = 1'b1; step(1);
    int_ack = 1'b0; step(1);
    eoi = 1'b1; step(1); eoi = 1'b0;
    chk("eoi0b_isr", isr, 8'h00);

    // Priority: irq 2 and 5 together, level held
    cfg_we = 1'b1; cfg_wdata = 8'h00; step(1); cfg_we = 1'b0;
    irq_in = 8'h24; step(3);
    chk("pri_req", {7'b0, int_req}, 8'h01);
    chk("pri_irr", irr, 8'h24);
    expect_vec(8'hD7, 1'b0);
    int_ack = 1'b1; step(1);
    chk("pri_isr2", isr, 8'h04);
    chk("pri_irr5", irr, 8'h20);
    int_ack = 1'b0; step(4);
    chk("pri_blocked", {7'b0, int_req}, 8'h00);
    eoi = 1'b1; step(1); eoi = 1'b0;
    step(2);
    chk("pri_second_req", {7'b0, int_req}, 8'h01);
    expect_vec(8'hEF, 1'b0);
    int_ack = 1'b1; step(1);
    chk("pri_isr5", isr, 8'h20);
    int_ack = 1'b0; step(1);
    eoi = 1'b1; step(1); eoi = 1'b0;
    irq_in = 8'h00; step(1);
    chk("held_level_no_reset", irr, 8'h00);

    // Nesting under irq 4
    irq_in = 8'h10; step(1); irq_in = 8'h00; step(2);
    chk("nest_req4", {7'b0, int_req}, 8'h01);
    expect_vec(8'hE7, 1'b0);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    chk("nest_isr4", isr, 8'h10);
    step(1);
    irq_in = 8'h02; step(1); irq_in = 8'h00; step(2);
    chk("nest_req1", {7'b0, int_req}, 8'h01);
    expect_vec(8'hCF, 1'b0);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    chk("nest_isr12", isr, 8'h12);
    step(1);
    irq_in = 8'h40; step(1); irq_in = 8'h00; step(3);
    chk("nest_low_no_req", {7'b0, int_req}, 8'h00);
    chk("nest_irr6", irr, 8'h40);
    eoi = 1'b1; step(1);
    chk("eoi_lowest", isr, 8'h10);
    step(1); eoi = 1'b0;
    chk("eoi_second", isr, 8'h00);
    step(2);
    chk("irq6_req", {7'b0, int_req}, 8'h01);
    expect_vec(8'hF7, 1'b0);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    chk("irq6_isr", isr, 8'h40);
    step(1);
    eoi = 1'b1; step(1); eoi = 1'b0;
    chk("irq6_eoi", isr, 8'h00);

    // Mask race, then acknowledge in IDLE
    irq_in = 8'h08; step(1); irq_in = 8'h00; step(2);
    chk("race_req", {7'b0, int_req}, 8'h01);
    cfg_we = 1'b1; cfg_wdata = 8'hFF; step(1); cfg_we = 1'b0;
    step(1);
    chk("race_req_drop", {7'b0, int_req}, 8'h00);
    expect_vec(8'hFF, 1'b1);
    int_ack = 1'b1; step(1);
    chk("spur_isr", isr, 8'h00);
    chk("spur_irr", irr, 8'h08);
    int_ack = 1'b0; step(1);

    // Timeout: unmask irq 3 and never acknowledge
    cfg_we = 1'b1; cfg_wdata = 8'hF7; step(1); cfg_we = 1'b0;
    step(2);
    chk("tmo_req_start", {7'b0, int_req}, 8'h01);
    step(14);
    chk("tmo_req_last", {7'b0, int_req}, 8'h01);
    expect_tmo();
    step(1);
    chk("tmo_pulse", {7'b0, ack_timeout}, 8'h01);
    chk("tmo_req_drop", {7'b0, int_req}, 8'h00);
    chk("tmo_irr_kept", irr, 8'h08);
    step(2);
    chk("tmo_rerequest", {7'b0, int_req}, 8'h01);

    // Reset in the middle of REQ
    rst_n = 1'b0; step(1);
    chk("midrst_int_req", {7'b0, int_req}, 8'h00);
    chk("midrst_irr", irr, 8'h00);
    chk("midrst_isr", isr, 8'h00);
    chk("midrst_vector", vector, 8'h00);
    rst_n = 1'b1;
    irq_in = 8'h01; step(1); irq_in = 8'h00; step(3);
    chk("midrst_imr_masked", {7'b0, int_req}, 8'h00);
    chk("midrst_irr_latched", irr, 8'h01);

    step(2);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
